// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core.
// Sequences IF/ID/EX/MEM/WB, produces the per-stage activate strobes and the
// PC/IR/RF/memory write gates, counts retired instructions and parks on HALT.
// All outputs are registered copies of a Moore decode of the next state, so
// they always equal the decode of the current state without any glitch path.
module multicycle_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [6:0]       opcode,
    input  logic             halt_req,
    output logic             actIF,
    output logic             actID,
    output logic             actEX,
    output logic             actMEM,
    output logic             actWB,
    output logic             IR_WE,
    output logic             PC_WE,
    output logic             writeEn,
    output logic             I_MEM_CSN,
    output logic             D_MEM_CSN,
    output logic             D_MEM_WEN,
    output logic [CNT_W-1:0] NUM_INST,
    output logic             HALT,
    output logic [2:0]       state
);

    localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LAT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_IF     = 3'd1;
    localparam logic [2:0] S_ID     = 3'd2;
    localparam logic [2:0] S_EX     = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALTED = 3'd6;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // Output vector layout:
    // [11]actIF [10]actID [9]actEX [8]actMEM [7]actWB [6]IR_WE [5]PC_WE
    // [4]writeEn [3]I_MEM_CSN [2]D_MEM_CSN [1]D_MEM_WEN [0]HALT
    localparam logic [11:0] OUT_IDLE = 12'h00E;

    // Opcodes that finish through WB without touching data memory.
    function automatic logic is_wb_only(input logic [6:0] op);
        logic r;
        case (op)
            OPC_OP, OPC_OPIMM, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR: r = 1'b1;
            default:                      r = 1'b0;
        endcase
        return r;
    endfunction

    // Opcodes that retire directly out of EX (branches and anything illegal).
    function automatic logic retires_in_ex(input logic [6:0] op);
        return !is_wb_only(op) && (op != OPC_LOAD) && (op != OPC_STORE);
    endfunction

    // Moore decode of (state, last-wait-cycle flag, latched opcode).
    function automatic logic [11:0] decode_outputs(input logic [2:0] st,
                                                   input logic       last,
                                                   input logic [6:0] op);
        logic [11:0] v;
        v = OUT_IDLE;
        case (st)
            S_IF: begin
                v[11] = 1'b1;
                v[6]  = last;
                v[3]  = 1'b0;
            end
            S_ID: begin
                v[10] = 1'b1;
            end
            S_EX: begin
                v[9]  = 1'b1;
                v[5]  = retires_in_ex(op);
            end
            S_MEM: begin
                v[8]  = 1'b1;
                v[2]  = 1'b0;
                v[1]  = !((op == OPC_STORE) && last);
                v[5]  = (op == OPC_STORE) && last;
            end
            S_WB: begin
                v[7]  = 1'b1;
                v[5]  = 1'b1;
                v[4]  = 1'b1;
            end
            S_HALTED: begin
                v[0]  = 1'b1;
            end
            default: begin
                v = OUT_IDLE;
            end
        endcase
        return v;
    endfunction

    logic [2:0]        state_r;
    logic [WAIT_W-1:0] wait_r;
    logic [6:0]        op_r;
    logic [CNT_W-1:0]  num_inst_r;
    logic [11:0]       out_r;

    logic [2:0]        next_state_s;
    logic [WAIT_W-1:0] next_wait_s;
    logic [6:0]        next_op_s;
    logic              last_s;
    logic              next_last_s;
    logic              count_s;
    logic [11:0]       cur_out_s;

    // Next-state, wait-counter and retirement logic.
    always_comb begin
        next_state_s = S_IDLE;
        next_wait_s  = '0;
        last_s       = (wait_r == WAIT_LAST);
        next_op_s    = (state_r == S_ID) ? opcode : op_r;
        case (state_r)
            S_IDLE:   next_state_s = S_IF;
            S_IF:     next_state_s = last_s ? S_ID : S_IF;
            S_ID:     next_state_s = halt_req ? S_HALTED : S_EX;
            S_EX: begin
                if (is_wb_only(op_r)) begin
                    next_state_s = S_WB;
                end else if ((op_r == OPC_LOAD) || (op_r == OPC_STORE)) begin
                    next_state_s = S_MEM;
                end else begin
                    next_state_s = S_IF;
                end
            end
            S_MEM: begin
                if (!last_s) begin
                    next_state_s = S_MEM;
                end else if (op_r == OPC_LOAD) begin
                    next_state_s = S_WB;
                end else begin
                    next_state_s = S_IF;
                end
            end
            S_WB:     next_state_s = S_IF;
            S_HALTED: next_state_s = S_HALTED;
            default:  next_state_s = S_IDLE;
        endcase
        if (((state_r == S_IF) || (state_r == S_MEM)) && !last_s) begin
            next_wait_s = wait_r + WAIT_W'(1);
        end else begin
            next_wait_s = '0;
        end
        next_last_s = (next_wait_s == WAIT_LAST);
        cur_out_s   = decode_outputs(state_r, last_s, op_r);
        // A halting instruction is counted even though it never asserts PC_WE.
        count_s     = cur_out_s[5] || ((state_r == S_ID) && halt_req);
    end

    // FSM state, wait counter, latched opcode and retired-instruction counter.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r    <= S_IDLE;
            wait_r     <= '0;
            op_r       <= 7'd0;
            num_inst_r <= '0;
        end else begin
            state_r <= next_state_s;
            wait_r  <= next_wait_s;
            op_r    <= next_op_s;
            if (count_s) begin
                num_inst_r <= num_inst_r + CNT_W'(1);
            end else begin
                num_inst_r <= num_inst_r;
            end
        end
    end

    // Registered output strobes, decoded from the state being entered.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            out_r <= OUT_IDLE;
        end else begin
            out_r <= decode_outputs(next_state_s, next_last_s, next_op_s);
        end
    end

    assign actIF     = out_r[11];
    assign actID     = out_r[10];
    assign actEX     = out_r[9];
    assign actMEM    = out_r[8];
    assign actWB     = out_r[7];
    assign IR_WE     = out_r[6];
    assign PC_WE     = out_r[5];
    assign writeEn   = out_r[4];
    assign I_MEM_CSN = out_r[3];
    assign D_MEM_CSN = out_r[2];
    assign D_MEM_WEN = out_r[1];
    assign HALT      = out_r[0];
    assign NUM_INST  = num_inst_r;
    assign state     = state_r;

endmodule
